// File: rtl/layer5_reader_pkg.sv
// Shared types and helpers for the layer-5 result reader.
// Optional build macro: LAYER5_READER_RELU_EN (clamp negative lanes on capture).
package layer5_reader_pkg;

   // Sequencer states: one FETCH bubble per pixel, then SEND for all beats.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Default geometry: 128-bit result word sent as four 32-bit beats.
   localparam int DEF_DATA_W = 128;
   localparam int DEF_BEAT_W = 32;
   localparam int BEATS      = DEF_DATA_W / DEF_BEAT_W;

   // Counter width for n values; a counter is never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // ReLU on one signed lane of width w (w <= 64): negative lanes become 0.
   function automatic logic [63:0] relu_lane(input logic [63:0] lane, input int w);
      return lane[6'(w - 1)] ? 64'd0 : lane;
   endfunction

endpackage

// File: rtl/layer5_beat_serializer.sv
// Holds one captured result word and streams it as BEAT_W beats, LSB beat first.
// With LAYER5_READER_RELU_EN defined, negative LANE_W lanes are clamped to 0 on capture.
module layer5_beat_serializer
   import layer5_reader_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int BEAT_W = 32,
   parameter int LANE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              send,
   input  logic              last_pixel,
   input  logic              out_ready,
   output logic [BEAT_W-1:0] out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic              pixel_done
);

   localparam int NBEATS = DATA_W / BEAT_W;
   localparam int BCW    = cnt_w(NBEATS);
   localparam int LANES  = DATA_W / LANE_W;

   logic [DATA_W-1:0] word_q, word_d;
   logic [DATA_W-1:0] cap_word;
   logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
   logic              fire;
   logic              last_beat;

   // Per-lane capture path: clamp or pass-through depending on build.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef LAYER5_READER_RELU_EN
      assign cap_word[i*LANE_W +: LANE_W] =
         LANE_W'(relu_lane(64'(load_data[i*LANE_W +: LANE_W]), LANE_W));
`else
      assign cap_word[i*LANE_W +: LANE_W] = load_data[i*LANE_W +: LANE_W];
`endif
   end

   assign fire       = send && out_ready;
   assign last_beat  = (beat_cnt_q == BCW'(NBEATS - 1));
   assign pixel_done = fire && last_beat;

   // Beat outputs derive only from registered state, so they stay put while stalled.
   assign out_valid = send;
   assign out_last  = send && last_pixel && last_beat;
   assign out_data  = send ? word_q[int'(beat_cnt_q)*BEAT_W +: BEAT_W] : '0;

   // Next word / beat index: load on fetch, advance only on an accepted beat.
   always_comb begin
      word_d     = word_q;
      beat_cnt_d = beat_cnt_q;
      if (load) begin
         word_d     = cap_word;
         beat_cnt_d = '0;
      end else if (fire) begin
         beat_cnt_d = last_beat ? '0 : BCW'(beat_cnt_q + 1'b1);
      end
   end

   // Word register and beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q     <= '0;
         beat_cnt_q <= '0;
      end else begin
         word_q     <= word_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: rtl/layer5_result_reader.sv
// Read-side sequencer for the layer-5 result memory: raster-walks the MAP_W x MAP_W map,
// reads each result word and hands it to the beat serializer.
// Optional build macro: LAYER5_READER_RELU_EN (clamp negative lanes on capture).
module layer5_result_reader
   import layer5_reader_pkg::*;
#(
   parameter int MAP_W  = 8,
   parameter int DATA_W = 128,
   parameter int BEAT_W = 32,
   parameter int LANE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [15:0]       read_row_addr,
   output logic [15:0]       read_col_addr,
   output logic              layer5_result_read_signal,
   input  logic [DATA_W-1:0] layer5_result_output,
   output logic [BEAT_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   localparam int CW = cnt_w(MAP_W);

   state_t        state_q, state_d;
   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          final_pixel;
   logic          last_col;
   logic          pixel_done;

   assign last_col    = (col_q == CW'(MAP_W - 1));
   assign final_pixel = last_col && (row_q == CW'(MAP_W - 1));

   // Memory is combinational-read: enable only during the FETCH bubble.
   assign layer5_result_read_signal = (state_q == FETCH);
   assign read_row_addr             = 16'(row_q);
   assign read_col_addr             = 16'(col_q);
   assign busy                      = busy_q;
   assign done                      = done_q;

   // Sequencer next-state, raster counters and registered status flags.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      case (state_q)
         IDLE:  if (start) state_d = FETCH;
         FETCH: state_d = SEND;
         SEND: begin
            if (pixel_done) begin
               if (final_pixel) begin
                  // Counters rewind so the next map starts at (0,0).
                  state_d = DONE;
                  row_d   = '0;
                  col_d   = '0;
               end else begin
                  state_d = FETCH;
                  if (last_col) begin
                     col_d = '0;
                     row_d = CW'(row_q + 1'b1);
                  end else begin
                     col_d = CW'(col_q + 1'b1);
                  end
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // Sequencer state; reset discards any partial map.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   layer5_beat_serializer #(
      .DATA_W (DATA_W),
      .BEAT_W (BEAT_W),
      .LANE_W (LANE_W)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .load       (state_q == FETCH),
      .load_data  (layer5_result_output),
      .send       (state_q == SEND),
      .last_pixel (final_pixel),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .pixel_done (pixel_done)
   );

endmodule
